// File: rtl/elevator_motion.sv
// Per-car motion sequencer for the two-car controller: floor, direction and door state
// for each car, advanced by a shared tick. Bit 1 of every paired signal is car 1, bit 0 is car 2.
//
// state     | meaning
// ST_STOP   | parked at a floor, deciding: open door, reverse, idle or depart
// ST_DOOR   | door open, dwell counter running, restarted by stop requests
// ST_TRAVEL | moving one floor, travel counter running
module elevator_motion #(
    parameter int NUM_FLOORS   = 7,
    parameter int TRAVEL_TICKS = 2,
    parameter int DOOR_TICKS   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic [1:0] turn,
    input  logic       stop_1,
    input  logic       stop_2,
    output logic [2:0] curr_elevator_1,
    output logic [2:0] curr_elevator_2,
    output logic [1:0] dir_elevator,
    output logic [1:0] door_open,
    output logic [1:0] arrive
);

    localparam int TW = (TRAVEL_TICKS > 1) ? $clog2(TRAVEL_TICKS) : 1;
    localparam int DW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;
    localparam logic [2:0]    TOP_FLOOR   = 3'(NUM_FLOORS - 1);
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_TICKS - 1);
    localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_TICKS - 1);

    typedef enum logic [1:0] {
        ST_STOP   = 2'd0,
        ST_DOOR   = 2'd1,
        ST_TRAVEL = 2'd2
    } state_t;

    state_t        state      [2];
    logic [2:0]    floor      [2];
    logic [TW-1:0] travel_cnt [2];
    logic [DW-1:0] door_cnt   [2];
    logic [1:0]    flip;
    logic [1:0]    stop_req;

    assign stop_req        = {stop_1, stop_2};
    assign curr_elevator_1 = floor[1];
    assign curr_elevator_2 = floor[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                state[c]      <= ST_STOP;
                floor[c]      <= '0;
                travel_cnt[c] <= '0;
                door_cnt[c]   <= '0;
            end
            flip         <= '0;
            dir_elevator <= 2'b11;
            door_open    <= '0;
            arrive       <= '0;
        end else begin
            arrive <= '0;
            if (tick) begin
                for (int c = 0; c < 2; c++) begin
                    case (state[c])
                        ST_STOP: begin
                            if (stop_req[c]) begin
                                state[c]     <= ST_DOOR;
                                door_cnt[c]  <= '0;
                                door_open[c] <= 1'b1;
                                if (!turn[c]) flip[c] <= 1'b0;
                            end else if (( dir_elevator[c] && floor[c] == TOP_FLOOR) ||
                                         (!dir_elevator[c] && floor[c] == 3'd0)) begin
                                dir_elevator[c] <= ~dir_elevator[c];
                                flip[c]         <= 1'b1;
                            end else if (turn[c]) begin
                                // A second consecutive reversal request parks the car instead of ping-ponging.
                                if (!flip[c]) begin
                                    dir_elevator[c] <= ~dir_elevator[c];
                                    flip[c]         <= 1'b1;
                                end
                            end else begin
                                state[c]      <= ST_TRAVEL;
                                travel_cnt[c] <= '0;
                                flip[c]       <= 1'b0;
                            end
                        end
                        ST_TRAVEL: begin
                            if (travel_cnt[c] == TRAVEL_LAST) begin
                                floor[c]  <= dir_elevator[c] ? floor[c] + 3'd1 : floor[c] - 3'd1;
                                arrive[c] <= 1'b1;
                                state[c]  <= ST_STOP;
                            end else begin
                                travel_cnt[c] <= travel_cnt[c] + 1'b1;
                            end
                        end
                        ST_DOOR: begin
                            if (stop_req[c]) begin
                                door_cnt[c] <= '0;
                            end else if (door_cnt[c] == DOOR_LAST) begin
                                door_open[c] <= 1'b0;
                                state[c]     <= ST_STOP;
                            end else begin
                                door_cnt[c] <= door_cnt[c] + 1'b1;
                            end
                        end
                        default: state[c] <= ST_STOP;
                    endcase
                end
            end
        end
    end

endmodule
